// File: rtl/icache_refill_engine_if.sv
// Bus bundle between the instruction-cache refill engine and its environment.
// Groups the miss handshake, memory request/response channels, array fill
// port and busy status. The refill engine uses the master modport; the cache
// and memory side (or a testbench) uses the slave modport.
//   miss_*    : miss request from the cache (valid/ready + address)
//   mem_req_* : single line read request to memory (valid/ready + address)
//   mem_rsp_* : 32-bit response beats, no backpressure, per-beat error flag
//   fill_*    : one-cycle write of a complete {valid, tag, data} line
//   busy      : engine not idle
interface icache_refill_engine_if #(
   parameter int unsigned NFU                     = 2,
   parameter int unsigned NCACHE_ENTRIES          = 256,
   parameter int unsigned PHYSICAL_ADDRESS_LENGTH = 56
) ();

   localparam int unsigned CACHEINDEX            = $clog2(NCACHE_ENTRIES);
   localparam int unsigned CACHELINEINDEX        = $clog2(NFU * 4);
   localparam int unsigned CACHELINESIZE         = NFU * 32;
   localparam int unsigned TAGSIZE               = PHYSICAL_ADDRESS_LENGTH - CACHEINDEX
                                                   - CACHELINEINDEX;
   localparam int unsigned CACHELINESIZE_PRESENT = CACHELINESIZE + 1 + TAGSIZE;

   logic                               miss_valid;
   logic                               miss_ready;
   logic [PHYSICAL_ADDRESS_LENGTH-1:0] miss_address;

   logic                               mem_req_valid;
   logic                               mem_req_ready;
   logic [PHYSICAL_ADDRESS_LENGTH-1:0] mem_req_address;

   logic                               mem_rsp_valid;
   logic [31:0]                        mem_rsp_data;
   logic                               mem_rsp_error;

   logic                               fill_we;
   logic [CACHEINDEX-1:0]              fill_index;
   logic [CACHELINESIZE_PRESENT-1:0]   fill_line;
   logic                               fill_done;
   logic                               fill_error;

   logic                               busy;

   modport master (
      input  miss_valid, miss_address,
      output miss_ready,
      output mem_req_valid, mem_req_address,
      input  mem_req_ready,
      input  mem_rsp_valid, mem_rsp_data, mem_rsp_error,
      output fill_we, fill_index, fill_line, fill_done, fill_error,
      output busy
   );

   modport slave (
      output miss_valid, miss_address,
      input  miss_ready,
      input  mem_req_valid, mem_req_address,
      output mem_req_ready,
      output mem_rsp_valid, mem_rsp_data, mem_rsp_error,
      input  fill_we, fill_index, fill_line, fill_done, fill_error,
      input  busy
   );

endinterface

// File: rtl/icache_refill_engine.sv
// Instruction-cache refill engine. Accepts one line miss at a time, issues a
// single line-aligned read to memory, gathers NFU 32-bit response beats and
// writes the complete {valid, tag, data} line into the cache array in one
// cycle. A line with any errored beat is written with valid=0 so the slot is
// invalidated rather than left holding stale contents.
// Ports:
//   clk  : clock, all state on the rising edge
//   rst  : asynchronous active-high reset, aborts any refill in flight
//   bus  : icache_refill_engine_if.master (miss, mem request/response, fill, busy)
// Optional feature macro: ICACHE_REFILL_TIMEOUT_EN
//   When defined, a cycle counter runs in REQ/COLLECT, cleared on the request
//   handshake and on every beat; reaching TIMEOUT_CYCLES idle cycles forces an
//   errored (valid=0) line write. When undefined the engine waits indefinitely.
module icache_refill_engine #(
   parameter int unsigned NFU                     = 2,
   parameter int unsigned NCACHE_ENTRIES          = 256,
   parameter int unsigned PHYSICAL_ADDRESS_LENGTH = 56,
   parameter int unsigned TIMEOUT_CYCLES          = 255
) (
   input logic                    clk,
   input logic                    rst,
   icache_refill_engine_if.master bus
);

   localparam int unsigned CACHEINDEX     = $clog2(NCACHE_ENTRIES);
   localparam int unsigned CACHELINEINDEX = $clog2(NFU * 4);
   localparam int unsigned CACHELINESIZE  = NFU * 32;
   localparam int unsigned TAGSIZE        = PHYSICAL_ADDRESS_LENGTH - CACHEINDEX
                                            - CACHELINEINDEX;
   // One spare bit so the beat counter never wraps within a line.
   localparam int unsigned CNTW           = $clog2(NFU) + 1;

   typedef enum logic [1:0] {StIdle, StReq, StCollect, StWrite} state_e;

   state_e                             state_q, state_d;
   logic [CACHEINDEX-1:0]              index_q, index_d;
   logic [TAGSIZE-1:0]                 tag_q, tag_d;
   logic [PHYSICAL_ADDRESS_LENGTH-1:0] addr_q, addr_d;
   logic [CACHELINESIZE-1:0]           data_q, data_d;
   logic [CNTW-1:0]                    cnt_q, cnt_d;
   logic                               err_q, err_d;

`ifdef ICACHE_REFILL_TIMEOUT_EN
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   logic [TW-1:0] timer_q, timer_d;
   logic          idle_cycle;
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
`endif

   // Offset bits of the miss address are deliberately dropped.
   logic unused_offset;
   assign unused_offset = ^bus.miss_address[CACHELINEINDEX-1:0];

   always_comb begin
      state_d = state_q;
      index_d = index_q;
      tag_d   = tag_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = err_q;

      unique case (state_q)
         StIdle: begin
            if (bus.miss_valid) begin
               index_d = bus.miss_address[CACHELINEINDEX +: CACHEINDEX];
               tag_d   = bus.miss_address[PHYSICAL_ADDRESS_LENGTH-1 -: TAGSIZE];
               addr_d  = {bus.miss_address[PHYSICAL_ADDRESS_LENGTH-1:CACHELINEINDEX],
                          {CACHELINEINDEX{1'b0}}};
               data_d  = '0;
               cnt_d   = '0;
               err_d   = 1'b0;
               state_d = StReq;
            end
         end
         StReq: begin
            if (bus.mem_req_ready) begin
               state_d = StCollect;
            end
         end
         StCollect: begin
            if (bus.mem_rsp_valid) begin
               for (int k = 0; k < NFU; k++) begin
                  if (cnt_q == CNTW'(k)) begin
                     data_d[32*k +: 32] = bus.mem_rsp_data;
                  end
               end
               cnt_d = cnt_q + CNTW'(1);
               err_d = err_q | bus.mem_rsp_error;
               if (cnt_q == CNTW'(NFU - 1)) begin
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

`ifdef ICACHE_REFILL_TIMEOUT_EN
      // A handshake or beat restarts the window; only waiting cycles count.
      idle_cycle = ((state_q == StReq) && !bus.mem_req_ready) ||
                   ((state_q == StCollect) && !bus.mem_rsp_valid);
      timer_d    = '0;
      if (idle_cycle) begin
         if (timer_q == TW'(TIMEOUT_CYCLES - 1)) begin
            state_d = StWrite;
            err_d   = 1'b1;
         end else begin
            timer_d = timer_q + TW'(1);
         end
      end
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
         index_q <= '0;
         tag_q   <= '0;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         index_q <= index_d;
         tag_q   <= tag_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

`ifdef ICACHE_REFILL_TIMEOUT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         timer_q <= '0;
      end else begin
         timer_q <= timer_d;
      end
   end
`endif

   assign bus.miss_ready      = (state_q == StIdle);
   assign bus.mem_req_valid   = (state_q == StReq);
   assign bus.mem_req_address = addr_q;
   assign bus.busy            = (state_q != StIdle);
   assign bus.fill_we         = (state_q == StWrite);
   assign bus.fill_done       = (state_q == StWrite);
   assign bus.fill_error      = (state_q == StWrite) && err_q;
   assign bus.fill_index      = index_q;
   // Line is driven only during the write so the array port idles at zero.
   assign bus.fill_line       = (state_q == StWrite) ? {~err_q, tag_q, data_q} : '0;

endmodule

// File: tb/tb_icache_refill_engine.sv
module tb_icache_refill_engine;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   icache_refill_engine_if #(
      .NFU                     (2),
      .NCACHE_ENTRIES          (256),
      .PHYSICAL_ADDRESS_LENGTH (56)
   ) bus ();

   icache_refill_engine #(
      .NFU                     (2),
      .NCACHE_ENTRIES          (256),
      .PHYSICAL_ADDRESS_LENGTH (56),
      .TIMEOUT_CYCLES          (8)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present a miss for one cycle; returns in the REQ cycle.
   task automatic start_miss(input logic [55:0] addr);
      bus.miss_valid   = 1'b1;
      bus.miss_address = addr;
      tick();
      bus.miss_valid   = 1'b0;
      bus.miss_address = '0;
   endtask

   task automatic send_beat(input logic [31:0] data, input logic err);
      bus.mem_rsp_valid = 1'b1;
      bus.mem_rsp_data  = data;
      bus.mem_rsp_error = err;
      tick();
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      bus.mem_rsp_error = 1'b0;
   endtask

   task automatic test_reset();
      int seen;
      // Still in reset from the initial block.
      n_checks++;
      if (bus.miss_ready !== 1'b1 || bus.busy !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ctrl: got ready=%b busy=%b req=%b required 1 0 0",
                  bus.miss_ready, bus.busy, bus.mem_req_valid);
      end
      n_checks++;
      if (bus.fill_we !== 1'b0 || bus.fill_done !== 1'b0 || bus.fill_error !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_fill_strobes: got we=%b done=%b err=%b required 0 0 0",
                  bus.fill_we, bus.fill_done, bus.fill_error);
      end
      n_checks++;
      if (bus.mem_req_address !== 56'h0 || bus.fill_index !== 8'h0 ||
          bus.fill_line !== 110'h0) begin
         n_fail++;
         $display("FAIL reset_data: got addr=%h idx=%h line=%h required all 0",
                  bus.mem_req_address, bus.fill_index, bus.fill_line);
      end
      rst = 1'b0;
      tick();
      bus.mem_req_ready = 1'b1;
      start_miss(56'h5678);
      tick();                         // now in COLLECT
      send_beat(32'hAAAA5555, 1'b0);  // one of two beats collected
      #2 rst = 1'b1;                  // asynchronous, mid-cycle
      #1;
      n_checks++;
      if (bus.miss_ready !== 1'b1 || bus.busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_abort: got ready=%b busy=%b required 1 0",
                  bus.miss_ready, bus.busy);
      end
      tick();
      rst  = 1'b0;
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.fill_we === 1'b1) seen++;
         tick();
      end
      n_checks++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL reset_no_fill: got %0d fill_we cycles required 0", seen);
      end
   endtask

   task automatic test_basic();
      bus.mem_req_ready = 1'b1;
      start_miss(56'h1234);
      n_checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_address !== 56'h1230 ||
          bus.miss_ready !== 1'b0 || bus.busy !== 1'b1) begin
         n_fail++;
         $display("FAIL basic_req: got v=%b addr=%h ready=%b busy=%b required 1 1230 0 1",
                  bus.mem_req_valid, bus.mem_req_address, bus.miss_ready, bus.busy);
      end
      tick();
      send_beat(32'hDEADBEEF, 1'b0);
      send_beat(32'h01234567, 1'b0);
      n_checks++;
      if (bus.fill_we !== 1'b1 || bus.fill_done !== 1'b1 || bus.fill_error !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_strobes: got we=%b done=%b err=%b required 1 1 0",
                  bus.fill_we, bus.fill_done, bus.fill_error);
      end
      n_checks++;
      if (bus.fill_index !== 8'h46) begin
         n_fail++;
         $display("FAIL basic_index: got %h required 46", bus.fill_index);
      end
      n_checks++;
      if (bus.fill_line !== {1'b1, 45'h2, 64'h01234567_DEADBEEF}) begin
         n_fail++;
         $display("FAIL basic_line: got %h required %h", bus.fill_line,
                  {1'b1, 45'h2, 64'h01234567_DEADBEEF});
      end
      tick();
      n_checks++;
      if (bus.miss_ready !== 1'b1 || bus.fill_we !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_return_idle: got ready=%b we=%b required 1 0",
                  bus.miss_ready, bus.fill_we);
      end
   endtask

   task automatic test_req_stall();
      int good;
      bus.mem_req_ready = 1'b0;
      start_miss(56'h2A08);
      good = 0;
      for (int i = 0; i < 6; i++) begin
         if (bus.mem_req_valid === 1'b1 && bus.mem_req_address === 56'h2A08) good++;
         if (i == 5) bus.mem_req_ready = 1'b1;
         tick();
      end
      n_checks++;
      if (good !== 6) begin
         n_fail++;
         $display("FAIL stall_req_stable: got %0d good cycles required 6", good);
      end
      n_checks++;
      if (bus.mem_req_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_single_req: got valid=%b required 0", bus.mem_req_valid);
      end
      send_beat(32'h89ABCDEF, 1'b0);
      send_beat(32'h76543210, 1'b0);
      n_checks++;
      if (bus.fill_we !== 1'b1 || bus.fill_index !== 8'h41 ||
          bus.fill_line !== {1'b1, 45'h5, 64'h76543210_89ABCDEF}) begin
         n_fail++;
         $display("FAIL stall_fill: got we=%b idx=%h line=%h required 1 41 %h",
                  bus.fill_we, bus.fill_index, bus.fill_line,
                  {1'b1, 45'h5, 64'h76543210_89ABCDEF});
      end
      tick();
   endtask

   task automatic test_error();
      bus.mem_req_ready = 1'b1;
      send_beat(32'h55555555, 1'b1);  // stray beat while idle
      n_checks++;
      if (bus.busy !== 1'b0 || bus.miss_ready !== 1'b1 || bus.fill_we !== 1'b0) begin
         n_fail++;
         $display("FAIL error_stray_beat: got busy=%b ready=%b we=%b required 0 1 0",
                  bus.busy, bus.miss_ready, bus.fill_we);
      end
      start_miss(56'h0FF8);
      tick();
      send_beat(32'h11111111, 1'b0);
      send_beat(32'h22222222, 1'b1);
      n_checks++;
      if (bus.fill_we !== 1'b1 || bus.fill_error !== 1'b1 || bus.fill_done !== 1'b1) begin
         n_fail++;
         $display("FAIL error_strobes: got we=%b err=%b done=%b required 1 1 1",
                  bus.fill_we, bus.fill_error, bus.fill_done);
      end
      n_checks++;
      if (bus.fill_index !== 8'hFF || bus.fill_line !== {1'b0, 45'h1, 64'h22222222_11111111}) begin
         n_fail++;
         $display("FAIL error_line: got idx=%h line=%h required ff %h", bus.fill_index,
                  bus.fill_line, {1'b0, 45'h1, 64'h22222222_11111111});
      end
      tick();
   endtask

   task automatic test_back_to_back();
      bus.mem_req_ready = 1'b1;
      start_miss(56'hFF_FFFF_FFFF_FFFF);
      n_checks++;
      if (bus.mem_req_address !== 56'hFF_FFFF_FFFF_FFF8) begin
         n_fail++;
         $display("FAIL b2b_a_addr: got %h required fffffffffffff8", bus.mem_req_address);
      end
      tick();
      tick();
      tick();
      send_beat(32'hCAFEF00D, 1'b0);
      tick();
      send_beat(32'h0BADC0DE, 1'b0);
      n_checks++;
      if (bus.fill_we !== 1'b1 || bus.fill_index !== 8'hFF ||
          bus.fill_line !== {1'b1, 45'h1FFF_FFFF_FFFF, 64'h0BADC0DE_CAFEF00D}) begin
         n_fail++;
         $display("FAIL b2b_a_fill: got we=%b idx=%h line=%h required 1 ff %h",
                  bus.fill_we, bus.fill_index, bus.fill_line,
                  {1'b1, 45'h1FFF_FFFF_FFFF, 64'h0BADC0DE_CAFEF00D});
      end
      tick();
      // Second miss offered in the first idle cycle after the write.
      n_checks++;
      if (bus.miss_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL b2b_ready: got %b required 1", bus.miss_ready);
      end
      start_miss(56'hABCDE4);                        // cycle 1
      n_checks++;
      if (bus.mem_req_valid !== 1'b1 || bus.mem_req_address !== 56'hABCDE0) begin
         n_fail++;
         $display("FAIL b2b_b_req: got v=%b addr=%h required 1 abcde0",
                  bus.mem_req_valid, bus.mem_req_address);
      end
      tick();                                        // cycle 2
      send_beat(32'h13579BDF, 1'b0);                 // cycle 3
      n_checks++;
      if (bus.fill_we !== 1'b0) begin
         n_fail++;
         $display("FAIL b2b_b_early: got we=%b required 0", bus.fill_we);
      end
      send_beat(32'h2468ACE0, 1'b0);                 // cycle 4
      n_checks++;
      if (bus.fill_we !== 1'b1 || bus.fill_index !== 8'hBC ||
          bus.fill_line !== {1'b1, 45'h1579, 64'h2468ACE0_13579BDF}) begin
         n_fail++;
         $display("FAIL b2b_b_fill: got we=%b idx=%h line=%h required 1 bc %h",
                  bus.fill_we, bus.fill_index, bus.fill_line,
                  {1'b1, 45'h1579, 64'h2468ACE0_13579BDF});
      end
      tick();
   endtask

`ifdef ICACHE_REFILL_TIMEOUT_EN
   task automatic test_timeout();
      int n;
      bus.mem_req_ready = 1'b1;
      start_miss(56'h40);
      tick();                      // handshake done, first COLLECT cycle
      n = 0;
      while (n < 20 && bus.fill_we !== 1'b1) begin
         tick();
         n++;
      end
      n_checks++;
      if (n !== 8) begin
         n_fail++;
         $display("FAIL timeout_cycles: got %0d required 8", n);
      end
      n_checks++;
      if (bus.fill_error !== 1'b1 || bus.fill_line[109] !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_line: got err=%b valid=%b required 1 0",
                  bus.fill_error, bus.fill_line[109]);
      end
      tick();
   endtask
`endif

   initial begin
      n_checks          = 0;
      n_fail            = 0;
      rst               = 1'b1;
      bus.miss_valid    = 1'b0;
      bus.miss_address  = '0;
      bus.mem_req_ready = 1'b0;
      bus.mem_rsp_valid = 1'b0;
      bus.mem_rsp_data  = '0;
      bus.mem_rsp_error = 1'b0;
      tick();
      tick();
      test_reset();
      test_basic();
      test_req_stall();
      test_error();
      test_back_to_back();
`ifdef ICACHE_REFILL_TIMEOUT_EN
      test_timeout();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
